// File: rtl/pwm_shift_pkg.sv
// Shared types and constants for the PWM shift-register controller.
// Optional abort input is enabled with macro PWM_SHIFT_CTRL_ABORT_EN (see pwm_shift_ctrl).
package pwm_shift_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT_LO = 3'd1,
    SHIFT_HI = 3'd2,
    LATCH_HI = 3'd3,
    GAP      = 3'd4
  } state_t;

endpackage

// File: rtl/pwm_clk_div.sv
// Phase-length divider for pwm_shift_ctrl: a down-counter that reloads to
// DIV-1 and flags the last cycle of the current phase with tc.
// Not affected by macro PWM_SHIFT_CTRL_ABORT_EN.
module pwm_clk_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic reload,
  output logic tc
);

  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] LOAD = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Count down from DIV-1 after every reload, resting at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (reload) begin
      cnt <= LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/pwm_shift_ctrl.sv
// Serialises one WIDTH-bit duty word MSB first into an external shift
// register (sclk/sdo), then pulses latch and signals done.
// Every phase (each sclk half, latch, gap) lasts DIV clk cycles.
// Macro PWM_SHIFT_CTRL_ABORT_EN adds an abort input that cancels a transfer
// while bits are still being shifted.
module pwm_shift_ctrl
  import pwm_shift_pkg::*;
#(
  parameter int DIV   = 4,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid,
`ifdef PWM_SHIFT_CTRL_ABORT_EN
  input  logic             abort,
`endif
  output logic             ready,
  output logic             sclk,
  output logic             sdo,
  output logic             latch,
  output logic             busy,
  output logic             done
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic             tc;
  logic             reload;
  logic             last_bit;
  logic             abort_hit;
  logic             accept;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shadow;
  logic             rdy_en;
  logic             sclk_q;

  assign last_bit = (bit_cnt == LAST_BIT);
  assign accept   = (state == IDLE) && valid && ready;

  // Next-state logic; abort only matters while bits are being shifted.
  always_comb begin
    state_nxt = state;
    abort_hit = 1'b0;
`ifdef PWM_SHIFT_CTRL_ABORT_EN
    abort_hit = abort && ((state == SHIFT_LO) || (state == SHIFT_HI));
`endif
    case (state)
      IDLE:     if (accept) state_nxt = SHIFT_LO;
      SHIFT_LO: if (tc) state_nxt = SHIFT_HI;
      SHIFT_HI: if (tc) state_nxt = last_bit ? LATCH_HI : SHIFT_LO;
      LATCH_HI: if (tc) state_nxt = GAP;
      GAP:      if (tc) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    if (abort_hit) state_nxt = IDLE;
  end

  // Every state change restarts the phase timer.
  assign reload = (state_nxt != state);

  pwm_clk_div #(.DIV(DIV)) u_div (
    .clk    (clk),
    .reset  (reset),
    .reload (reload),
    .tc     (tc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Shadow word and bit counter: load on handshake, advance at each sclk high-phase end.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow  <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      shadow  <= data_in;
      bit_cnt <= '0;
    end else if ((state == SHIFT_HI) && tc) begin
      shadow <= shadow << 1;
      if (!last_bit) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Hold ready low for the first cycle after reset.
  always_ff @(posedge clk) begin
    if (reset) rdy_en <= 1'b0;
    else       rdy_en <= 1'b1;
  end

  // Registered shift clock, high exactly while the FSM sits in SHIFT_HI.
  always_ff @(posedge clk) begin
    if (reset) sclk_q <= 1'b0;
    else       sclk_q <= (state_nxt == SHIFT_HI);
  end

  assign ready = (state == IDLE) && rdy_en;
  assign busy  = (state != IDLE);
  assign sclk  = sclk_q;
  assign sdo   = ((state == SHIFT_LO) || (state == SHIFT_HI)) ? shadow[WIDTH-1] : 1'b0;
  assign latch = (state == LATCH_HI);
  assign done  = (state == GAP) && tc;

endmodule
